// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one imem request
// outstanding at most, and holds each fetched word until decode takes it.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    // Counter only needs to reach MEM_TIMEOUT-1; the hit cycle is the last one.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(MEM_TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] tcnt;
    logic          redirect_pend;
    logic          err_pend;

    logic slot_free;
    logic kill;
    logic misal;
    logic bad_now;
    logic tmo_hit;

    assign slot_free = !if_valid || !stall;
    assign kill      = redirect_valid || redirect_pend;
    assign misal     = redirect_pc[1:0] != 2'b00;
    assign bad_now   = err_pend || (redirect_valid && misal);
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (tcnt == TLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_VECTOR;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            fetch_err     <= 1'b0;
            err_cause     <= 2'b00;
            tcnt          <= '0;
            redirect_pend <= 1'b0;
            err_pend      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                        if (misal) begin
                            state     <= S_HALT;
                            fetch_err <= 1'b1;
                            err_cause <= CAUSE_MISALIGN;
                        end
                    end else begin
                        if (if_valid && !stall) begin
                            if_valid <= 1'b0;
                        end
                        if (slot_free) begin
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            tcnt      <= '0;
                        end
                    end
                end

                S_REQ: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                        if (misal) begin
                            err_pend <= 1'b1;
                        end
                    end
                    if (imem_ready) begin
                        imem_req      <= 1'b0;
                        redirect_pend <= 1'b0;
                        state         <= S_IDLE;
                        if (!kill) begin
                            if_instr <= imem_rdata;
                            if_pc    <= imem_addr;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                        end
                        if (bad_now) begin
                            state     <= S_HALT;
                            fetch_err <= 1'b1;
                            err_cause <= CAUSE_MISALIGN;
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                        if (redirect_valid) begin
                            redirect_pend <= 1'b1;
                        end
                        // A pending misaligned target is the earlier fault.
                        if (tmo_hit) begin
                            imem_req  <= 1'b0;
                            state     <= S_HALT;
                            fetch_err <= 1'b1;
                            err_cause <= bad_now ? CAUSE_MISALIGN
                                                 : CAUSE_TIMEOUT;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
